roi_pixel_streamer: RTL

- Source end of the colour-detect pixel-stream interface.
- Reads one 320×240 RGB565 frame from the camera frame buffer through a fixed-latency read port.
- Expands each pixel to RGB888 and emits `frame_start`, `pixel_valid`, `x_coord`, `y_coord` and `pixel_r`/`pixel_g`/`pixel_b`, in the timing the ROI colour detector counts against.
- Sits between the frame-buffer read port and the colour detector; the game FSM gates it with `enable`.

---
 rtl/color_detect_pkg.sv | 46 ++++
 rtl/pixel_delay_line.sv | 27 ++
 rtl/roi_pixel_streamer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/color_detect_pkg.sv
// Shared types, default frame dimensions and the RGB565 -> RGB888 expansion
// used by the colour-detect pixel path.
package color_detect_pkg;

  localparam int DEF_H_ACTIVE  = 320;
  localparam int DEF_V_ACTIVE  = 240;
  localparam int DEF_LINE_GAP  = 16;
  localparam int DEF_FRAME_GAP = 32;
  localparam int DEF_MEM_LAT   = 1;
  localparam int DEF_ADDR_W    = 17;

  localparam int COORD_W = 10;
  localparam int GAP_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ACTIVE,
    ST_LGAP,
    ST_FGAP
  } streamer_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic               sof;
    logic               valid;
    logic               last;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pixel_tag_t;

  // MSB replication so that full-scale 565 maps to full-scale 888
  function automatic rgb888_t rgb565_to_888(input logic [15:0] d);
    rgb888_t c;
    c.r = {d[15:11], d[15:13]};
    c.g = {d[10:5],  d[10:9]};
    c.b = {d[4:0],   d[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/pixel_delay_line.sv
// Fixed-depth shift register that carries per-read pixel tags alongside the
// frame-buffer read latency.
module pixel_delay_line
  import color_detect_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  pixel_tag_t tag_in,
  output pixel_tag_t tag_out
);

  pixel_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/roi_pixel_streamer.sv
// Raster-scans one frame out of the frame buffer and streams RGB888 pixels
// with coordinates. ROI_STREAMER_TEST_PATTERN_EN adds a colour-bar source.
//
// state  | meaning
// IDLE   | waiting for enable && frame_ready
// SOF    | one cycle, clears x/y/addr, launches frame_start
// ACTIVE | one read per cycle along the current line
// LGAP   | idle cycles between lines
// FGAP   | idle cycles after the last line
module roi_pixel_streamer
  import color_detect_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int LINE_GAP  = DEF_LINE_GAP,
  parameter int FRAME_GAP = DEF_FRAME_GAP,
  parameter int MEM_LAT   = DEF_MEM_LAT,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              frame_ready,
`ifdef ROI_STREAMER_TEST_PATTERN_EN
  input  logic              test_pattern,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              frame_start,
  output logic              pixel_valid,
  output logic [9:0]        x_coord,
  output logic [9:0]        y_coord,
  output logic [7:0]        pixel_r,
  output logic [7:0]        pixel_g,
  output logic [7:0]        pixel_b,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_ACTIVE - 1);
  localparam logic [GAP_W-1:0]   LG_LOAD = GAP_W'((LINE_GAP  > 0) ? LINE_GAP  - 1 : 0);
  localparam logic [GAP_W-1:0]   FG_LOAD = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  streamer_state_t    state, state_nxt;
  logic [COORD_W-1:0] x, y;
  logic [ADDR_W-1:0]  addr;
  logic [GAP_W-1:0]   gap_cnt;
  logic               sof;
  logic               frame_end;
  logic               last_q;
  pixel_tag_t         tag_in, tag_out;
  rgb888_t            pix_rgb;

  assign frame_end = (state == ST_ACTIVE) && (x == X_LAST) && (y == Y_LAST);
  assign mem_addr  = addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (enable && frame_ready) state_nxt = ST_SOF;
      ST_SOF:    state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        if (x == X_LAST) begin
          if (y != Y_LAST)        state_nxt = (LINE_GAP == 0) ? ST_ACTIVE : ST_LGAP;
          else if (FRAME_GAP != 0) state_nxt = ST_FGAP;
          else                    state_nxt = (enable && frame_ready) ? ST_SOF : ST_IDLE;
        end
      end
      ST_LGAP:   if (gap_cnt == '0) state_nxt = ST_ACTIVE;
      ST_FGAP:   if (gap_cnt == '0) state_nxt = (enable && frame_ready) ? ST_SOF : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state == ST_ACTIVE);
    sof       = (state == ST_SOF);
    busy      = (state != ST_IDLE);
  end

  // addr stops on the last pixel so it never points past the frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x       <= '0;
      y       <= '0;
      addr    <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_SOF: begin
          x    <= '0;
          y    <= '0;
          addr <= '0;
        end
        ST_ACTIVE: begin
          if (x != X_LAST) begin
            x    <= x + 1'b1;
            addr <= addr + 1'b1;
          end else if (y != Y_LAST) begin
            addr <= addr + 1'b1;
            if (LINE_GAP == 0) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              gap_cnt <= LG_LOAD;
            end
          end else begin
            gap_cnt <= FG_LOAD;
          end
        end
        ST_LGAP: begin
          if (gap_cnt == '0) begin
            x <= '0;
            y <= y + 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_FGAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign tag_in = '{sof: sof, valid: mem_rd_en, last: frame_end, x: x, y: y};

  pixel_delay_line #(.DEPTH(MEM_LAT)) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

`ifdef ROI_STREAMER_TEST_PATTERN_EN
  localparam logic [COORD_W-1:0] BAR1 = COORD_W'(V_ACTIVE / 3);
  localparam logic [COORD_W-1:0] BAR2 = COORD_W'((2 * V_ACTIVE) / 3);
  logic tp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          tp_q <= 1'b0;
    else if (state == ST_SOF) tp_q <= test_pattern;
  end

  always_comb begin
    pix_rgb = rgb565_to_888(mem_rdata);
    if (tp_q) begin
      if (tag_out.y < BAR1)      pix_rgb = '{r: 8'hFF, g: 8'h00, b: 8'h00};
      else if (tag_out.y < BAR2) pix_rgb = '{r: 8'h00, g: 8'hFF, b: 8'h00};
      else                       pix_rgb = '{r: 8'h00, g: 8'h00, b: 8'hFF};
    end
  end
`else
  assign pix_rgb = rgb565_to_888(mem_rdata);
`endif

  // final pipeline stage: read data is captured here, MEM_LAT cycles after the strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start <= 1'b0;
      pixel_valid <= 1'b0;
      last_q      <= 1'b0;
      frame_done  <= 1'b0;
      x_coord     <= '0;
      y_coord     <= '0;
      pixel_r     <= '0;
      pixel_g     <= '0;
      pixel_b     <= '0;
    end else begin
      frame_start <= tag_out.sof;
      pixel_valid <= tag_out.valid;
      last_q      <= tag_out.valid && tag_out.last;
      frame_done  <= last_q;
      if (tag_out.valid) begin
        x_coord <= tag_out.x;
        y_coord <= tag_out.y;
        pixel_r <= pix_rgb.r;
        pixel_g <= pix_rgb.g;
        pixel_b <= pix_rgb.b;
      end
    end
  end

endmodule
